output_result_buffer: RTL and testbench

//  Receiving end of the accumulator -> output buffer write interface (data, 4-bit addr, enable).
//  - Stores one 32-bit final result per address in a DEPTH-entry register file.
//  - On host command, drains a contiguous address range out on a valid/ready stream.
//  - Sits between the accumulator stage and the host/readback path of the systolic array.

---
 rtl/output_result_buffer.sv | 113 +++++++++++
 tb/tb_output_result_buffer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_result_buffer.sv
// Result register file fed by the accumulator write port, drained to the host
// over a valid/ready stream. Per-entry valid bits flag words that were never refreshed.
module output_result_buffer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              drain_start,
   input  logic [ADDR_W-1:0] drain_base,
   input  logic [ADDR_W:0]   drain_len,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_stale,
   output logic              busy,
   output logic              done,
   output logic              overwrite
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_FETCH   = 2'd1;
   localparam logic [1:0] S_PRESENT = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   rem;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  vld;

   // Storage has no reset; the valid bits alone decide whether a word is meaningful.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // A write to the entry being fetched lands after the clear, so it stays valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld <= '0;
      end else begin
         if (state == S_FETCH) begin
            vld[ptr] <= 1'b0;
         end
         if (wr_en) begin
            vld[wr_addr] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overwrite <= 1'b0;
      end else if (wr_en && vld[wr_addr]) begin
         overwrite <= 1'b1;
      end else if (state == S_IDLE && drain_start) begin
         overwrite <= 1'b0;
      end
   end

   // Each word takes a FETCH cycle into the output register, then waits in PRESENT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         rem       <= '0;
         out_data  <= '0;
         out_addr  <= '0;
         out_stale <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (drain_start) begin
                  ptr   <= drain_base;
                  rem   <= (drain_len == '0) ? (ADDR_W+1)'(DEPTH) : drain_len;
                  state <= S_FETCH;
               end
            end
            S_FETCH: begin
               out_data  <= mem[ptr];
               out_addr  <= ptr;
               out_stale <= ~vld[ptr];
               state     <= S_PRESENT;
            end
            S_PRESENT: begin
               if (out_ready) begin
                  ptr   <= ptr + 1'b1;
                  rem   <= rem - 1'b1;
                  state <= (rem == (ADDR_W+1)'(1)) ? S_DONE : S_FETCH;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign out_valid = (state == S_PRESENT);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

endmodule

// File: tb/tb_output_result_buffer.sv
// Directed bench for output_result_buffer: inputs change and outputs are sampled on the
// falling clock edge, away from the active rising edge.
module tb_output_result_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        drain_start = 1'b0;
   logic [3:0]  drain_base = '0;
   logic [4:0]  drain_len = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_addr;
   logic        out_stale;
   logic        busy;
   logic        done;
   logic        overwrite;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] got_data [16];
   logic [3:0]  got_addr [16];
   logic        got_stale [16];
   int          got_cnt;
   logic        done_after;
   bit          valid_ok;

   output_result_buffer dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .drain_start(drain_start), .drain_base(drain_base), .drain_len(drain_len),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_stale(out_stale), .busy(busy), .done(done),
      .overwrite(overwrite)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic write_word(input logic [3:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic start_drain(input logic [3:0] b, input logic [4:0] l);
      drain_start = 1'b1; drain_base = b; drain_len = l;
      @(negedge clk);
      drain_start = 1'b0;
   endtask

   task automatic wait_valid();
      valid_ok = 1'b0;
      for (int c = 0; c < 20 && !valid_ok; c++) begin
         if (out_valid) valid_ok = 1'b1;
         else @(negedge clk);
      end
      n_cmp++;
      if (!valid_ok) begin
         n_fail++;
         $display("[TB] FAIL wait_valid: out_valid=%0b, required 1 within 20 cycles", out_valid);
      end
   endtask

   // Accepts up to n words with out_ready high; returns one cycle after the last handshake.
   task automatic collect(input int n);
      out_ready = 1'b1;
      got_cnt = 0;
      for (int c = 0; c < 200 && got_cnt < n; c++) begin
         if (out_valid && got_cnt < 16) begin
            got_data[got_cnt]  = out_data;
            got_addr[got_cnt]  = out_addr;
            got_stale[got_cnt] = out_stale;
            got_cnt++;
         end
         @(negedge clk);
      end
      done_after = done;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      tick();
      n_cmp++;
      if ({out_valid, busy, done, overwrite, out_stale} !== 5'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: valid/busy/done/ovw/stale=%b, required 00000",
                  {out_valid, busy, done, overwrite, out_stale});
      end
      n_cmp++;
      if (out_data !== 32'h0 || out_addr !== 4'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_data: data=%h addr=%h, required 0/0", out_data, out_addr);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic_drain();
      for (int i = 0; i < 4; i++) write_word(4'(i), 32'hA0 + 32'(i));
      start_drain(4'd0, 5'd4);
      collect(4);
      n_cmp++;
      if (got_cnt !== 4) begin
         n_fail++;
         $display("[TB] FAIL basic_count: got %0d words, required 4", got_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (got_data[i] !== 32'hA0 + 32'(i) || got_addr[i] !== 4'(i) || got_stale[i] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_word%0d: data=%h addr=%0d stale=%b, required %h/%0d/0",
                     i, got_data[i], got_addr[i], got_stale[i], 32'hA0 + 32'(i), i);
         end
      end
      n_cmp++;
      if (done_after !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL basic_done: done=%b after last handshake, required 1", done_after);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_idle: done=%b busy=%b, required 0/0", done, busy);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_d [4];
      logic [3:0]  exp_a [4];
      exp_d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
      for (int i = 0; i < 4; i++) write_word(exp_a[i], exp_d[i]);
      start_drain(4'd14, 5'd4);
      collect(4);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (got_data[i] !== exp_d[i] || got_addr[i] !== exp_a[i] || got_stale[i] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wrap_word%0d: data=%h addr=%0d stale=%b, required %h/%0d/0",
                     i, got_data[i], got_addr[i], got_stale[i], exp_d[i], exp_a[i]);
         end
      end
      tick();
      write_word(4'd7, 32'h77);
      start_drain(4'd8, 5'd0);
      collect(16);
      n_cmp++;
      if (got_cnt !== 16 || done_after !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL full_count: words=%0d done=%b, required 16/1", got_cnt, done_after);
      end
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if (got_addr[i] !== 4'(8 + i) || got_stale[i] !== (i != 15)) begin
            n_fail++;
            $display("[TB] FAIL full_word%0d: addr=%0d stale=%b, required %0d/%b",
                     i, got_addr[i], got_stale[i], 4'(8 + i), (i != 15));
         end
      end
      n_cmp++;
      if (got_data[15] !== 32'h77) begin
         n_fail++;
         $display("[TB] FAIL full_addr7_data: data=%h, required 00000077", got_data[15]);
      end
      tick();
   endtask

   task automatic test_stale_overwrite();
      write_word(4'd2, 32'h21);
      write_word(4'd2, 32'h22);
      tick();
      n_cmp++;
      if (overwrite !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL ovw_set: overwrite=%b, required 1", overwrite);
      end
      start_drain(4'd5, 5'd1);
      n_cmp++;
      if (overwrite !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL ovw_clear: overwrite=%b, required 0", overwrite);
      end
      collect(1);
      n_cmp++;
      if (got_addr[0] !== 4'd5 || got_stale[0] !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL stale_addr5: addr=%0d stale=%b, required 5/1", got_addr[0], got_stale[0]);
      end
      tick();
   endtask

   task automatic test_backpressure();
      write_word(4'd9, 32'h99);
      start_drain(4'd9, 5'd1);
      wait_valid();
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== 32'h99 || out_addr !== 4'd9) begin
            n_fail++;
            $display("[TB] FAIL hold_cycle%0d: valid=%b data=%h addr=%0d, required 1/00000099/9",
                     k, out_valid, out_data, out_addr);
         end
         if (k == 1) write_word(4'd9, 32'hDEAD);
         else tick();
      end
      collect(1);
      n_cmp++;
      if (got_data[0] !== 32'h99 || got_stale[0] !== 1'b0 || overwrite !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL hold_accept: data=%h stale=%b ovw=%b, required 00000099/0/0",
                  got_data[0], got_stale[0], overwrite);
      end
      tick();
      start_drain(4'd9, 5'd1);
      collect(1);
      n_cmp++;
      if (got_data[0] !== 32'hDEAD || got_stale[0] !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL hold_rewrite: data=%h stale=%b, required 0000dead/0", got_data[0], got_stale[0]);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      start_drain(4'd2, 5'd2);
      wait_valid();
      start_drain(4'd10, 5'd3);
      collect(2);
      n_cmp++;
      if (got_cnt !== 2 || got_addr[0] !== 4'd2 || got_addr[1] !== 4'd3) begin
         n_fail++;
         $display("[TB] FAIL busy_ignore_addr: words=%0d addr=%0d,%0d, required 2 words 2,3",
                  got_cnt, got_addr[0], got_addr[1]);
      end
      n_cmp++;
      if (got_data[0] !== 32'h22 || got_stale[0] !== 1'b0 || got_stale[1] !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL busy_ignore_data: data=%h stale=%b,%b, required 00000022 0,1",
                  got_data[0], got_stale[0], got_stale[1]);
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL busy_ignore_idle: busy=%b, required 0", busy);
      end
      write_word(4'd12, 32'hC11);
      wr_en = 1'b1; wr_addr = 4'd12; wr_data = 32'hC12;
      drain_start = 1'b1; drain_base = 4'd12; drain_len = 5'd1;
      tick();
      wr_en = 1'b0; drain_start = 1'b0;
      n_cmp++;
      if (overwrite !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL same_cycle_flags: ovw=%b busy=%b, required 1/1", overwrite, busy);
      end
      collect(1);
      n_cmp++;
      if (got_data[0] !== 32'hC12 || got_addr[0] !== 4'd12 || got_stale[0] !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL same_cycle_word: data=%h addr=%0d stale=%b, required 00000c12/12/0",
                  got_data[0], got_addr[0], got_stale[0]);
      end
      tick();
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < 4; i++) write_word(4'(i), 32'h60 + 32'(i));
      start_drain(4'd0, 5'd4);
      wait_valid();
      write_word(4'd3, 32'h63A);
      n_cmp++;
      if (overwrite !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL abort_ovw_pre: overwrite=%b, required 1", overwrite);
      end
      collect(2);
      n_cmp++;
      if (got_data[0] !== 32'h60 || got_data[1] !== 32'h61) begin
         n_fail++;
         $display("[TB] FAIL abort_first_words: data=%h,%h, required 00000060,00000061",
                  got_data[0], got_data[1]);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, busy, done, overwrite} !== 4'b0) begin
         n_fail++;
         $display("[TB] FAIL abort_async: valid/busy/done/ovw=%b, required 0000",
                  {out_valid, busy, done, overwrite});
      end
      @(negedge clk);
      rst = 1'b1;
      tick(); tick(); tick();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL abort_no_done: done=%b busy=%b, required 0/0", done, busy);
      end
      start_drain(4'd0, 5'd4);
      collect(4);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (got_addr[i] !== 4'(i) || got_stale[i] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL abort_stale%0d: addr=%0d stale=%b, required %0d/1",
                     i, got_addr[i], got_stale[i], i);
         end
      end
      n_cmp++;
      if (done_after !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL abort_redrain_done: done=%b, required 1", done_after);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_drain();
      test_wrap();
      test_stale_overwrite();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
